// File: rtl/stream_source_pkg.sv
// Shared definitions for the stream_source range generator: FSM state
// encoding and default widths. The element width defaults to the
// project-wide integer width (intN = 8 bits).
package stream_source_pkg;

    // Project-wide integer width used for stream elements by default.
    localparam int INT_N         = 8;
    localparam int DEFAULT_WIDTH = INT_N;
    localparam int DEFAULT_LEN_W = 8;

    // Call life cycle: waiting for a call, streaming elements, holding the
    // completion until it is accepted.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : stream_source_pkg

// File: rtl/stream_source_if.sv
// Bundle of the three handshakes of stream_source: the call (in_*), the
// completion (out_*) and the produced stream (sOut*). The master modport is
// the generator side; the slave modport is its caller / stream consumer.
// Optional macro STREAM_SOURCE_STEP_EN adds the per-call step input.
interface stream_source_if
    import stream_source_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LEN_W = DEFAULT_LEN_W
);
    // Call request
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] start;
    logic [LEN_W-1:0] len;
`ifdef STREAM_SOURCE_STEP_EN
    logic [WIDTH-1:0] step;
`endif
    // Completion
    logic             out_valid;
    logic             out_ready;
    logic [LEN_W-1:0] out_count;
    // Produced stream
    logic [WIDTH-1:0] sOut;
    logic             sOut_valid;
    logic             sOut_ready;

`ifdef STREAM_SOURCE_STEP_EN
    modport master (
        input  in_valid, start, len, step, out_ready, sOut_ready,
        output in_ready, out_valid, out_count, sOut, sOut_valid
    );
    modport slave (
        output in_valid, start, len, step, out_ready, sOut_ready,
        input  in_ready, out_valid, out_count, sOut, sOut_valid
    );
`else
    modport master (
        input  in_valid, start, len, out_ready, sOut_ready,
        output in_ready, out_valid, out_count, sOut, sOut_valid
    );
    modport slave (
        output in_valid, start, len, out_ready, sOut_ready,
        input  in_ready, out_valid, out_count, sOut, sOut_valid
    );
`endif

endinterface : stream_source_if

// File: rtl/stream_source.sv
// stream_source: accepts a call (start, len), emits the counting stream
// start, start+step, ... (len elements, modulo 2^WIDTH) under backpressure,
// then returns a completion carrying the number of elements emitted.
// Optional macro STREAM_SOURCE_STEP_EN: the increment is taken from the
// call's step input; otherwise the increment is fixed at 1.
// All outputs are registered except in_ready, which is decoded from state,
// so no valid ever depends combinationally on a ready.
module stream_source
    import stream_source_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic            clk,
    input  logic            nrst,
    stream_source_if.master bus
);

    state_e           state_q;
    logic [WIDTH-1:0] sout_q;
    logic             sout_valid_q;
    logic             out_valid_q;
    logic [LEN_W-1:0] out_count_q;
    logic [LEN_W-1:0] remaining_q;
    logic [WIDTH-1:0] step_w;
    logic [WIDTH-1:0] sout_d;
    logic             xfer_w;

`ifdef STREAM_SOURCE_STEP_EN
    logic [WIDTH-1:0] step_q;

    // Step is captured with start so a caller may change it mid-stream.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step_q <= WIDTH'(1);
        end else if (state_q == ST_IDLE && bus.in_valid) begin
            step_q <= bus.step;
        end
    end

    assign step_w = step_q;
`else
    assign step_w = WIDTH'(1);
`endif

    // Successor element wraps naturally at 2^WIDTH.
    assign sout_d = sout_q + step_w;

    // An element is taken when it is offered and the consumer is ready.
    assign xfer_w = sout_valid_q && bus.sOut_ready;

    // Call FSM with registered stream, completion and count outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            sout_q       <= '0;
            sout_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_count_q  <= '0;
            remaining_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        out_count_q <= '0;
                        if (bus.len == '0) begin
                            // Empty call: complete straight away.
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            sout_q       <= bus.start;
                            sout_valid_q <= 1'b1;
                            remaining_q  <= bus.len;
                            state_q      <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Without a transfer everything holds, keeping the
                    // offered element stable while stalled.
                    if (xfer_w) begin
                        out_count_q <= out_count_q + LEN_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            // Last element taken: the data register keeps
                            // its final value, only valid drops.
                            sout_valid_q <= 1'b0;
                            out_valid_q  <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            sout_q <= sout_d;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    sout_valid_q <= 1'b0;
                    out_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.sOut       = sout_q;
    assign bus.sOut_valid = sout_valid_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_count  = out_count_q;

endmodule : stream_source

// File: tb/tb_stream_source.sv
// Bench for stream_source: a queue-based model of each call (the list of
// elements still owed, the completion owed, the count delivered) is checked
// against the DUT every falling edge, plus directed calls with literal
// expectations and a batch of randomized calls under random backpressure.
module tb_stream_source;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    stream_source_if #(.WIDTH(8), .LEN_W(8)) bus ();

    stream_source #(.WIDTH(8), .LEN_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.master)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] seen[$];
    int         seen_cyc[$];
    logic [7:0] exp_q[$];

    // Model state: elements still to be delivered, completion pending, count.
    logic [7:0] mq[$];
    bit         mdone = 1'b0;
    int         mcount = 0;

    bit pat [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] cur_step();
`ifdef STREAM_SOURCE_STEP_EN
        return bus.step;
`else
        return 8'd1;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle model compare, then advance the model by the coming edge.
    always @(negedge clk) begin : model
        bit idle;
        if (!nrst) begin
            chk("rst_sOut_valid", {31'b0, bus.sOut_valid}, 32'd0);
            chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
            mq.delete();
            mdone  = 1'b0;
            mcount = 0;
        end else begin
            if (bus.sOut_valid && bus.sOut_ready) begin
                seen.push_back(bus.sOut);
                seen_cyc.push_back(cyc);
            end
            idle = (mq.size() == 0) && !mdone;
            chk("m_in_ready", {31'b0, bus.in_ready}, {31'b0, idle});
            chk("m_sOut_valid", {31'b0, bus.sOut_valid}, {31'b0, mq.size() > 0});
            if (mq.size() > 0) chk("m_sOut", {24'b0, bus.sOut}, {24'b0, mq[0]});
            chk("m_out_valid", {31'b0, bus.out_valid}, {31'b0, mdone});
            if (mdone) chk("m_out_count", {24'b0, bus.out_count}, mcount);
            if (idle) begin
                if (bus.in_valid) begin
                    mcount = 0;
                    if (bus.len == 8'd0) mdone = 1'b1;
                    else for (int i = 0; i < int'(bus.len); i++)
                        mq.push_back(8'(int'(bus.start) + i * int'(cur_step())));
                end
            end else if (mq.size() > 0) begin
                if (bus.sOut_ready) begin
                    void'(mq.pop_front());
                    mcount++;
                    if (mq.size() == 0) mdone = 1'b1;
                end
            end else if (bus.out_ready) begin
                mdone = 1'b0;
            end
        end
    end

    // One complete call: issue, drive backpressure (mode 0 always ready,
    // 1 fixed pattern, 2 random), wait for completion, accept it after od cycles.
    task automatic do_call(input logic [7:0] st, input logic [7:0] ln, input logic [7:0] stp,
                           input int mode, input int od,
                           output int acc, output int dcyc, output logic [7:0] dcnt);
        int eff_step;
`ifdef STREAM_SOURCE_STEP_EN
        eff_step = int'(stp);
`else
        eff_step = 1;
`endif
        seen.delete();
        seen_cyc.delete();
        dcyc = -1;
        dcnt = 8'hxx;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.start = st; bus.len = ln;
`ifdef STREAM_SOURCE_STEP_EN
        bus.step = stp;
`endif
        bus.sOut_ready = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk); acc = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            case (mode)
                0: bus.sOut_ready = 1'b1;
                1: bus.sOut_ready = (k < 6) ? pat[k] : 1'b1;
                default: begin
                    bus.sOut_ready = 1'($urandom_range(0, 1));
                    bus.in_valid   = 1'($urandom_range(0, 1));
                    bus.start      = 8'($urandom);
                    bus.len        = 8'($urandom);
                end
            endcase
            @(negedge clk);
            if (bus.out_valid) begin
                dcyc = cyc;
                dcnt = bus.out_count;
                break;
            end
            @(posedge clk); #1;
        end
        chk("call_completes", {31'b0, dcyc >= 0}, 32'd1);
        for (int i = 0; i < od; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.sOut_ready = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_while_done", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after_out_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("out_valid_cleared", {31'b0, bus.out_valid}, 32'd0);
        chk("n_elems", seen.size(), {24'b0, ln});
        chk("done_count", {24'b0, dcnt}, {24'b0, ln});
        for (int i = 0; i < seen.size() && i < int'(ln); i++)
            chk("elem_value", {24'b0, seen[i]}, {24'b0, 8'(int'(st) + i * eff_step)});
    endtask

    // Compare the delivered elements against the literal list in exp_q.
    task automatic chk_seen(input string name);
        chk(name, seen.size(), exp_q.size());
        for (int i = 0; i < seen.size() && i < exp_q.size(); i++)
            chk(name, {24'b0, seen[i]}, {24'b0, exp_q[i]});
    endtask

    // Absolute time limit so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a, d;
        logic [7:0] c;
        bus.in_valid = 1'b0; bus.start = '0; bus.len = '0;
        bus.out_ready = 1'b0; bus.sOut_ready = 1'b0;
`ifdef STREAM_SOURCE_STEP_EN
        bus.step = 8'd1;
`endif
        // Reset state
        @(negedge clk);
        chk("rst_sOut", {24'b0, bus.sOut}, 32'd0);
        chk("rst_out_count", {24'b0, bus.out_count}, 32'd0);
        @(posedge clk); #1; nrst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);
        $display("[TB] reset released, in_ready=%0d", bus.in_ready);

        // start=5, len=4, always ready: 5,6,7,8 back to back
        do_call(8'd5, 8'd4, 8'd1, 0, 0, a, d, c);
        exp_q = {8'd5, 8'd6, 8'd7, 8'd8};
        chk_seen("t1_elems");
        if (seen_cyc.size() == 4) begin
            chk("t1_first_cycle", seen_cyc[0], a + 1);
            chk("t1_last_cycle", seen_cyc[3], a + 4);
        end
        chk("t1_done_cycle", d, a + 5);
        chk("t1_count", {24'b0, c}, 32'd4);
        $display("[TB] call start=5 len=4: %0d elems, count=%0d", seen.size(), c);

        // start=0, len=3, ready 1,0,0,1,0,1
        do_call(8'd0, 8'd3, 8'd1, 1, 0, a, d, c);
        exp_q = {8'd0, 8'd1, 8'd2};
        chk_seen("t2_elems");
        if (seen_cyc.size() == 3) begin
            chk("t2_cycle0", seen_cyc[0], a + 1);
            chk("t2_cycle1", seen_cyc[1], a + 4);
            chk("t2_cycle2", seen_cyc[2], a + 6);
        end
        chk("t2_done_cycle", d, a + 7);
        $display("[TB] call start=0 len=3 stalled: %0d elems, count=%0d", seen.size(), c);

        // len=0: immediate completion, no elements
        do_call(8'd7, 8'd0, 8'd1, 0, 1, a, d, c);
        exp_q.delete();
        chk_seen("t3_elems");
        chk("t3_done_cycle", d, a + 1);
        chk("t3_count", {24'b0, c}, 32'd0);
        $display("[TB] call len=0: %0d elems, count=%0d", seen.size(), c);

        // Wrap-around
        do_call(8'hFE, 8'd4, 8'd1, 0, 0, a, d, c);
        exp_q = {8'hFE, 8'hFF, 8'h00, 8'h01};
        chk_seen("t4_elems");
        $display("[TB] call start=FE len=4: %0d elems", seen.size());

        // Reset during RUN after two of five elements
        seen.delete();
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.start = 8'd10; bus.len = 8'd5; bus.sOut_ready = 1'b1;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; nrst = 1'b0;
        @(negedge clk);
        chk("t5_sOut_valid_in_reset", {31'b0, bus.sOut_valid}, 32'd0);
        chk("t5_out_valid_in_reset", {31'b0, bus.out_valid}, 32'd0);
        chk("t5_elems_before_reset", seen.size(), 32'd2);
        @(posedge clk); #1; bus.sOut_ready = 1'b0;
        @(posedge clk); #1; nrst = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_after", {31'b0, bus.in_ready}, 32'd1);
        chk("t5_no_completion", {31'b0, bus.out_valid}, 32'd0);
        do_call(8'd9, 8'd1, 8'd1, 0, 0, a, d, c);
        exp_q = {8'd9};
        chk_seen("t5_new_call");
        $display("[TB] reset mid-stream then call start=9 len=1: %0d elems", seen.size());

`ifdef STREAM_SOURCE_STEP_EN
        do_call(8'd1, 8'd3, 8'd3, 0, 0, a, d, c);
        exp_q = {8'd1, 8'd4, 8'd7};
        chk_seen("t6_step3");
        do_call(8'd1, 8'd2, 8'd0, 0, 0, a, d, c);
        exp_q = {8'd1, 8'd1};
        chk_seen("t6_step0");
        $display("[TB] step calls done");
`endif

        // Randomized calls under random backpressure and ignored in_valid
        for (int n = 0; n < 40; n++) begin
            logic [7:0] rs, rl, rp;
            int ro;
            rs = 8'($urandom);
            rl = 8'($urandom_range(0, 12));
            rp = 8'($urandom);
            ro = $urandom_range(0, 3);
            do_call(rs, rl, rp, 2, ro, a, d, c);
            $display("[TB] rand call %0d start=%0h len=%0d: %0d elems count=%0d",
                     n, rs, rl, seen.size(), c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_stream_source
